// File: rtl/fractal_sync_tx.sv
// Fractal sync node transmit datapath: round-robin arbitration between the
// right (ch 0) and left (ch 1) request FIFOs, optional merge of matching
// heads, and a programmable minimum gap between upstream sync pulses.

package fractal_sync_pkg;
  typedef struct packed {
    logic [3:0] aggr;
    logic [3:0] id;
  } fsync_sig_t;

  typedef struct packed {
    logic       sync;
    fsync_sig_t sig;
    logic [1:0] src;
  } fsync_req_t;
endpackage

module fractal_sync_tx #(
  parameter type         fsync_req_t = fractal_sync_pkg::fsync_req_t,
  parameter bit          MERGE_EN    = 1'b1,
  parameter int unsigned GAP_CYCLES  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            empty_i,
  input  fsync_req_t [1:0]      req_i,
  output logic [1:0]            pop_o,
  output fsync_req_t            req_o,
  output logic                  busy_o
);

  localparam logic [7:0] GAP_LD = 8'(GAP_CYCLES);

  fsync_req_t req_q, req_d;
  logic [7:0] gap_q, gap_d;
  logic       ptr_q, ptr_d;

  logic       both_vld;
  logic       any_vld;
  logic       merge;
  logic       sel;

  // Grant / merge decision, pop generation and next-state for the launch regs
  always_comb begin
    pop_o      = 2'b00;
    ptr_d      = ptr_q;
    req_d      = req_q;
    req_d.sync = 1'b0;
    gap_d      = (gap_q != 8'd0) ? gap_q - 8'd1 : 8'd0;

    both_vld = ~empty_i[0] & ~empty_i[1];
    any_vld  = ~empty_i[0] | ~empty_i[1];
    merge    = MERGE_EN && both_vld &&
               (req_i[0].sig.id   == req_i[1].sig.id) &&
               (req_i[0].sig.aggr == req_i[1].sig.aggr);
    // With both heads valid the pointer decides; otherwise the lone valid one.
    sel      = both_vld ? ptr_q : empty_i[0];

    if (!rst_i && gap_q == 8'd0) begin
      if (merge) begin
        pop_o          = 2'b11;
        req_d          = req_i[0];
        req_d.src      = req_i[0].src | req_i[1].src;
        req_d.sync     = 1'b1;
        ptr_d          = ~ptr_q;
        gap_d          = GAP_LD;
      end else if (any_vld) begin
        pop_o[sel]     = 1'b1;
        req_d          = req_i[sel];
        req_d.sync     = 1'b1;
        ptr_d          = ~sel;
        gap_d          = GAP_LD;
      end
    end
  end

  // Launch register, gap counter and round-robin pointer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q <= '0;
      gap_q <= 8'd0;
      ptr_q <= 1'b0;
    end else begin
      req_q <= req_d;
      gap_q <= gap_d;
      ptr_q <= ptr_d;
    end
  end

  assign req_o  = req_q;
  assign busy_o = !rst_i && ((gap_q != 8'd0) || (empty_i != 2'b11));

endmodule

// File: tb/tb_fractal_sync_tx.sv
// Directed bench for fractal_sync_tx: a vector table against the default
// configuration, plus hand sequences for the gap and no-merge variants.
module tb_fractal_sync_tx;
  import fractal_sync_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] empty = 2'b11;
  fsync_req_t [1:0] req_in;

  logic [1:0] pop_d, pop_g, pop_n;
  fsync_req_t req_d, req_g, req_n;
  logic busy_d, busy_g, busy_n;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fractal_sync_tx #(.MERGE_EN(1'b1), .GAP_CYCLES(0)) u_def (
    .clk_i(clk), .rst_i(rst), .empty_i(empty), .req_i(req_in),
    .pop_o(pop_d), .req_o(req_d), .busy_o(busy_d));

  fractal_sync_tx #(.MERGE_EN(1'b1), .GAP_CYCLES(2)) u_gap (
    .clk_i(clk), .rst_i(rst), .empty_i(empty), .req_i(req_in),
    .pop_o(pop_g), .req_o(req_g), .busy_o(busy_g));

  fractal_sync_tx #(.MERGE_EN(1'b0), .GAP_CYCLES(0)) u_nm (
    .clk_i(clk), .rst_i(rst), .empty_i(empty), .req_i(req_in),
    .pop_o(pop_n), .req_o(req_n), .busy_o(busy_n));

  typedef struct {
    logic       rst;
    logic [1:0] emp;
    logic [3:0] id0, ag0; logic [1:0] s0;
    logic [3:0] id1, ag1; logic [1:0] s1;
    logic [1:0] pop;
    logic       sync;
    logic [3:0] id, ag;
    logic [1:0] src;
    logic       busy;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_head(input int ch, input logic [3:0] id,
                          input logic [3:0] ag, input logic [1:0] src);
    req_in[ch]          = '0;
    req_in[ch].sig.id   = id;
    req_in[ch].sig.aggr = ag;
    req_in[ch].src      = src;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    empty = 2'b11;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int rem;
    logic [1:0] emp_n;

    req_in = '0;
    //            rst emp  id0 ag0 s0  id1 ag1 s1 | pop sync id ag src busy
    tbl[0]  = '{1, 2'd0, 1, 1, 1, 2, 2, 2,  0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 2'd0, 1, 1, 1, 2, 2, 2,  1, 0, 0, 0, 0, 1};
    tbl[2]  = '{0, 2'd0, 1, 1, 1, 2, 2, 2,  2, 1, 1, 1, 1, 1};
    tbl[3]  = '{0, 2'd0, 1, 1, 1, 2, 2, 2,  1, 1, 2, 2, 2, 1};
    tbl[4]  = '{0, 2'd0, 1, 1, 1, 2, 2, 2,  2, 1, 1, 1, 1, 1};
    tbl[5]  = '{0, 2'd3, 1, 1, 1, 2, 2, 2,  0, 1, 2, 2, 2, 0};
    tbl[6]  = '{0, 2'd3, 1, 1, 1, 2, 2, 2,  0, 0, 2, 2, 2, 0};
    tbl[7]  = '{0, 2'd2, 3, 6, 1, 0, 0, 0,  1, 0, 2, 2, 2, 1};
    tbl[8]  = '{0, 2'd2, 3, 6, 1, 0, 0, 0,  1, 1, 3, 6, 1, 1};
    tbl[9]  = '{0, 2'd2, 3, 6, 1, 0, 0, 0,  1, 1, 3, 6, 1, 1};
    tbl[10] = '{0, 2'd3, 3, 6, 1, 0, 0, 0,  0, 1, 3, 6, 1, 0};
    tbl[11] = '{0, 2'd0, 5, 2, 1, 5, 2, 2,  3, 0, 3, 6, 1, 1};
    tbl[12] = '{0, 2'd3, 5, 2, 1, 5, 2, 2,  0, 1, 5, 2, 3, 0};
    tbl[13] = '{0, 2'd0, 1, 1, 1, 2, 2, 2,  1, 0, 5, 2, 3, 1};
    tbl[14] = '{0, 2'd3, 1, 1, 1, 2, 2, 2,  0, 1, 1, 1, 1, 0};
    tbl[15] = '{0, 2'd2, 7, 3, 1, 7, 3, 2,  1, 0, 1, 1, 1, 1};
    tbl[16] = '{0, 2'd3, 7, 3, 1, 7, 3, 2,  0, 1, 7, 3, 1, 0};
    tbl[17] = '{0, 2'd0, 1, 1, 1, 2, 2, 2,  2, 0, 7, 3, 1, 1};
    tbl[18] = '{1, 2'd0, 1, 1, 1, 2, 2, 2,  0, 0, 0, 0, 0, 0};
    tbl[19] = '{0, 2'd0, 1, 1, 1, 2, 2, 2,  1, 0, 0, 0, 0, 1};
    tbl[20] = '{0, 2'd3, 1, 1, 1, 2, 2, 2,  0, 1, 1, 1, 1, 0};

    // Default config: reset, round-robin, single channel, merge, mid-run reset
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      rst   = tbl[i].rst;
      empty = tbl[i].emp;
      set_head(0, tbl[i].id0, tbl[i].ag0, tbl[i].s0);
      set_head(1, tbl[i].id1, tbl[i].ag1, tbl[i].s1);
      #1;
      chk($sformatf("v%0d pop", i),  pop_d,             tbl[i].pop);
      chk($sformatf("v%0d sync", i), req_d.sync,        tbl[i].sync);
      chk($sformatf("v%0d id", i),   req_d.sig.id,      tbl[i].id);
      chk($sformatf("v%0d aggr", i), req_d.sig.aggr,    tbl[i].ag);
      chk($sformatf("v%0d src", i),  req_d.src,         tbl[i].src);
      chk($sformatf("v%0d busy", i), busy_d,            tbl[i].busy);
    end

    // Gap config: three left requests, pulses spaced GAP_CYCLES+1 apart
    do_reset();
    rem = 3;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      empty = (rem == 0) ? 2'b11 : 2'b01;
      set_head(0, 4'd0, 4'd0, 2'b00);
      set_head(1, 4'(11 - rem), 4'd4, 2'b10);
      #1;
      chk($sformatf("gap c%0d pop", c),  pop_g,
          (c == 0 || c == 3 || c == 6) ? 2 : 0);
      chk($sformatf("gap c%0d sync", c), req_g.sync,
          (c == 1 || c == 4 || c == 7) ? 1 : 0);
      chk($sformatf("gap c%0d busy", c), busy_g, (c <= 8) ? 1 : 0);
      if (c == 1 || c == 4 || c == 7)
        chk($sformatf("gap c%0d id", c), req_g.sig.id, 8 + (c - 1) / 3);
      if (pop_g[1] && rem > 0) rem--;
    end

    // No-merge config: identical heads launch separately, right first
    do_reset();
    emp_n = 2'b00;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      empty = emp_n;
      set_head(0, 4'd5, 4'd2, 2'b01);
      set_head(1, 4'd5, 4'd2, 2'b10);
      #1;
      chk($sformatf("nm c%0d pop", c), pop_n,
          (c == 0) ? 1 : (c == 1) ? 2 : 0);
      chk($sformatf("nm c%0d sync", c), req_n.sync, (c == 1 || c == 2) ? 1 : 0);
      if (c == 1) chk("nm c1 src", req_n.src, 1);
      if (c == 2) chk("nm c2 src", req_n.src, 2);
      if (c == 1 || c == 2) chk($sformatf("nm c%0d id", c), req_n.sig.id, 5);
      emp_n = emp_n | pop_n;
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
